// File: rtl/sync_gry_bin.sv
// Synchronizes a foreign-domain gray-coded count, decodes it to binary, and reports the per-cycle advance.
// Latency: a stable i_gry change appears on o_bin/o_vld at the (SYNC_STAGES+1)th i_clk edge.
// Backpressure: none; o_vld is a single-cycle strobe that the consumer must take in the same cycle.
//
// Ports:
//   i_clk      destination clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_gry      gray-coded value from the source domain (<= 1 bit change per source step)
//   i_err_clr  synchronous clear of o_err (only used when the checker is compiled in)
//   o_bin      registered binary decode of the synchronized gray value
//   o_vld      pulse: o_bin took a new value this cycle
//   o_dlt      o_bin advance modulo 2^DATA_WIDTH, valid with o_vld, held otherwise
//   o_err      sticky flag: synchronized gray moved by more than one bit in one cycle
//
// Build option: define SYNC_GRY_CHK_EN to include the multi-bit transition checker;
// without it o_err is tied low and i_err_clr is ignored.
module sync_gry_bin #(
  parameter int DATA_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_gry,
  input  logic                  i_err_clr,
  output logic [DATA_WIDTH-1:0] o_bin,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_dlt,
  output logic                  o_err
);

  localparam int LAST = SYNC_STAGES - 1;

  // Fewer than two stages gives no metastability settling time.
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_gry_bin: SYNC_STAGES must be >= 2");
  end

  // Plain flop chain; no logic may sit between stages.
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= i_gry;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  logic [DATA_WIDTH-1:0] bin_d;

  always_comb begin
    bin_d             = '0;
    bin_d[DATA_WIDTH-1] = sync_q[LAST][DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      bin_d[i] = bin_d[i+1] ^ sync_q[LAST][i];
    end
  end

  logic [DATA_WIDTH-1:0] bin_q;
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] dlt_q;
  logic                  vld_d;
  logic [DATA_WIDTH-1:0] dlt_d;

  // Subtraction wraps naturally, so 15 -> 0 reads as an advance of 1.
  assign vld_d = (bin_d != bin_q);
  assign dlt_d = bin_d - bin_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_q <= '0;
      vld_q <= 1'b0;
      dlt_q <= '0;
    end else begin
      bin_q <= bin_d;
      vld_q <= vld_d;
      // Delta is held when nothing moved so it stays readable after the strobe.
      if (vld_d) begin
        dlt_q <= dlt_d;
      end
    end
  end

  assign o_bin = bin_q;
  assign o_vld = vld_q;
  assign o_dlt = dlt_q;

`ifdef SYNC_GRY_CHK_EN
  logic [DATA_WIDTH-1:0] prev_q;
  logic                  err_q;
  logic                  viol;
  logic                  err_d;

  assign viol  = ($countones(sync_q[LAST] ^ prev_q) > 1);
  // A fresh violation in the same cycle as a clear keeps the flag set.
  assign err_d = viol | (err_q & ~i_err_clr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= sync_q[LAST];
      err_q  <= err_d;
    end
  end

  assign o_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign o_err          = 1'b0;
`endif

endmodule
